// File: rtl/alu_mc_pkg.sv
// Shared op codes, FSM state encoding and op classification for the multi-cycle ALU.
// Pure definitions; no timing or handshake behaviour lives here.
package alu_mc_pkg;

  localparam logic [2:0] OP_SRA = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic isShiftOp(input logic [2:0] opCode);
    return (opCode == OP_SRA) || (opCode == OP_SRL) || (opCode == OP_SLL);
  endfunction

endpackage

// File: rtl/alu_mc_shifter.sv
// Iterative shifter: working register shifted one bit per cycle while a down-counter runs to zero.
// Latency equals the loaded amount; no handshake, the owner sequences load and watches last.
module alu_mc_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dir,
  input  logic             arith,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] dout,
  output logic             last
);

  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;

  // dout is the working value after one more step, so the owner can capture the final value on the last edge.
  always_comb begin
    dout = work;
    if (dir) begin
      dout = {work[WIDTH-2:0], 1'b0};
    end else begin
      dout = {arith & work[WIDTH-1], work[WIDTH-1:1]};
    end
  end

  assign last = (cnt == SHW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
    end else if (load) begin
      work <= din;
      cnt  <= amt;
    end else if (cnt != '0) begin
      work <= dout;
      cnt  <= cnt - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with flags: single-cycle ops in 1 cycle, shifts by sh take sh+1 cycles (sh==0 bypasses).
// One op in flight; result and flags held in DONE until out_ready, in_ready only while IDLE.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   sh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
    logic             zero;
  } result_t;

  state_t           state, stateNext;
  logic [2:0]       opReg;
  result_t          result, aluOut;
  logic             accept, load;
  logic [WIDTH-1:0] shDout;
  logic             shLast;
  logic [WIDTH:0]   sum, diff;

  alu_mc_shifter #(.WIDTH(WIDTH), .SHW(SHW)) uShifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .dir   (opReg == OP_SLL),
    .arith (opReg == OP_SRA),
    .din   (a),
    .amt   (sh),
    .dout  (shDout),
    .last  (shLast)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:  if (in_valid) stateNext = (isShiftOp(op) && sh != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (shLast) stateNext = ST_DONE;
      ST_DONE:  if (out_ready) stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
    accept    = (state == ST_IDLE) && in_valid;
    load      = accept && isShiftOp(op) && (sh != '0);
  end

  // Borrow for SUB falls out as the top bit of the zero-extended difference.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    aluOut = '0;
    case (op)
      OP_SRA, OP_SRL, OP_SLL: aluOut.res = a;
      OP_SUB: begin
        aluOut.res   = diff[WIDTH-1:0];
        aluOut.carry = diff[WIDTH];
        aluOut.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADD: begin
        aluOut.res   = sum[WIDTH-1:0];
        aluOut.carry = sum[WIDTH];
        aluOut.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: aluOut.res = a & b;
      OP_OR:  aluOut.res = a | b;
      OP_SLT: aluOut.res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: aluOut.res = a;
    endcase
    aluOut.zero = (aluOut.res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      opReg  <= OP_SRA;
    end else begin
      if (accept) begin
        opReg <= op;
      end
      if (accept && !load) begin
        result <= aluOut;
      end else if (state == ST_SHIFT && shLast) begin
        result <= '{res: shDout, carry: 1'b0, ovf: 1'b0, zero: (shDout == '0)};
      end
    end
  end

  assign res   = result.res;
  assign carry = result.carry;
  assign ovf   = result.ovf;
  assign zero  = result.zero;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=8: expected results queued at issue, popped when out_valid rises.
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic [2:0] sh = 3'd0;
  logic       in_ready, out_valid, carry, ovf, zero, busy;
  logic [7:0] res;

  typedef struct {
    logic [7:0] res;
    logic       carry;
    logic       ovf;
    logic       zero;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_mc #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .sh        (sh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                 input logic [2:0] s);
    exp_t e;
    int   si;
    logic [8:0] w;
    e.res = 8'd0; e.carry = 1'b0; e.ovf = 1'b0;
    case (o)
      3'd0: e.res = $signed(x) >>> s;
      3'd1: e.res = x >> s;
      3'd2: begin
        e.res = x - y; e.carry = (x < y);
        si = $signed(x) - $signed(y); e.ovf = (si > 127) || (si < -128);
      end
      3'd3: begin
        w = {1'b0, x} + {1'b0, y}; e.res = w[7:0]; e.carry = w[8];
        si = $signed(x) + $signed(y); e.ovf = (si > 127) || (si < -128);
      end
      3'd4: e.res = x << s;
      3'd5: e.res = x & y;
      3'd6: e.res = x | y;
      default: e.res = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
    endcase
    e.zero = (e.res == 8'd0);
    e.lat  = ((o == 3'd0 || o == 3'd1 || o == 3'd4) && s != 3'd0) ? int'(s) + 1 : 1;
    return e;
  endfunction

  task automatic sendOp(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input logic [2:0] s);
    @(negedge clk);
    op = o; a = x; b = y; sh = s; in_valid = 1'b1;
    for (int i = 0; i < 40 && in_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitResult(output int lat, output logic busyAll, output logic ok);
    lat = 0; busyAll = 1'b1; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (busy !== 1'b1) busyAll = 1'b0;
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    int hits;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (res !== 8'd0) begin errors++; $display("FAIL reset_res: got %h required 00", res); end
    checks++; if ({carry, ovf, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b required 000", {carry, ovf, zero}); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid_busy: got %b%b required 00", out_valid, busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    sendOp(3'd0, 8'h90, 8'h00, 3'd7);
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_shift: busy=%b out_valid=%b required 1 0", busy, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_shift: out_valid=%b busy=%b in_ready=%b required 0 0 1", out_valid, busy, in_ready);
    end
    checks++; if (res !== 8'd0) begin errors++; $display("FAIL reset_mid_shift_res: got %h required 00", res); end
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) hits++;
    end
    checks++; if (hits != 0) begin errors++; $display("FAIL discarded_op: out_valid high %0d cycles required 0", hits); end
  endtask

  task automatic test_arith;
    logic [2:0] tOp[8];
    logic [7:0] tA[8], tB[8], tRes[8];
    logic       tC[8], tV[8];
    exp_t e;
    int lat; logic busyAll, ok;
    tOp  = '{3'd3, 3'd3, 3'd2, 3'd7, 3'd7, 3'd5, 3'd6, 3'd2};
    tA   = '{8'h7F, 8'hFF, 8'h03, 8'hFE, 8'h01, 8'hF0, 8'hF0, 8'h80};
    tB   = '{8'h01, 8'h01, 8'h05, 8'h01, 8'hFE, 8'h3C, 8'h0C, 8'h01};
    tRes = '{8'h80, 8'h00, 8'hFE, 8'h01, 8'h00, 8'h30, 8'hFC, 8'h7F};
    tC   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tV   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      sendOp(tOp[i], tA[i], tB[i], 3'd0);
      sb.push_back('{tRes[i], tC[i], tV[i], tRes[i] == 8'h00, 1});
      waitResult(lat, busyAll, ok);
      checks++; if (!ok) begin errors++; $display("FAIL arith_timeout[%0d]: no out_valid within 40 cycles", i); end
      e = sb.pop_front();
      checks++; if (res !== e.res) begin errors++; $display("FAIL arith_res[%0d]: got %h required %h", i, res, e.res); end
      checks++; if ({carry, ovf, zero} !== {e.carry, e.ovf, e.zero}) begin
        errors++; $display("FAIL arith_flags[%0d]: cvz got %b required %b", i, {carry, ovf, zero}, {e.carry, e.ovf, e.zero});
      end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL arith_latency[%0d]: got %0d required %0d", i, lat, e.lat); end
      ack();
    end
  endtask

  task automatic test_shift;
    logic [2:0] tOp[6], tSh[6];
    logic [7:0] tA[6], tRes[6];
    int tLat[6];
    exp_t e;
    int lat; logic busyAll, ok;
    tOp  = '{3'd0, 3'd1, 3'd4, 3'd0, 3'd1, 3'd0};
    tA   = '{8'h90, 8'h90, 8'h81, 8'hA5, 8'h01, 8'h80};
    tSh  = '{3'd3, 3'd3, 3'd7, 3'd0, 3'd1, 3'd7};
    tRes = '{8'hF2, 8'h12, 8'h80, 8'hA5, 8'h00, 8'hFF};
    tLat = '{4, 4, 8, 1, 2, 8};
    for (int i = 0; i < 6; i++) begin
      sendOp(tOp[i], tA[i], 8'h5A, tSh[i]);
      sb.push_back('{tRes[i], 1'b0, 1'b0, tRes[i] == 8'h00, tLat[i]});
      waitResult(lat, busyAll, ok);
      checks++; if (!ok) begin errors++; $display("FAIL shift_timeout[%0d]: no out_valid within 40 cycles", i); end
      e = sb.pop_front();
      checks++; if (res !== e.res) begin errors++; $display("FAIL shift_res[%0d]: got %h required %h", i, res, e.res); end
      checks++; if ({carry, ovf, zero} !== {e.carry, e.ovf, e.zero}) begin
        errors++; $display("FAIL shift_flags[%0d]: cvz got %b required %b", i, {carry, ovf, zero}, {e.carry, e.ovf, e.zero});
      end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL shift_latency[%0d]: got %0d required %0d", i, lat, e.lat); end
      checks++; if (busyAll !== 1'b1) begin errors++; $display("FAIL shift_busy[%0d]: busy dropped before result, required high", i); end
      ack();
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    int lat, bad; logic busyAll, ok;
    sendOp(3'd3, 8'h05, 8'h03, 3'd0);
    sb.push_back('{8'h08, 1'b0, 1'b0, 1'b0, 1});
    waitResult(lat, busyAll, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: no out_valid within 40 cycles"); end
    e = sb.pop_front();
    checks++; if (res !== e.res) begin errors++; $display("FAIL bp_first_res: got %h required %h", res, e.res); end
    op = 3'd6; a = 8'h0F; b = 8'hF0; sh = 3'd0; in_valid = 1'b1;
    sb.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 1});
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (res !== e.res || {carry, ovf, zero} !== {e.carry, e.ovf, e.zero} || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles required 0", bad); end
    ack();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    waitResult(lat, busyAll, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_second_timeout: no out_valid within 40 cycles"); end
    e = sb.pop_front();
    checks++; if (res !== e.res || lat != e.lat) begin
      errors++; $display("FAIL bp_second: res %h lat %0d required %h lat %0d", res, lat, e.res, e.lat);
    end
    ack();
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int lat, bad; logic busyAll, ok;
    logic [2:0] o, s;
    logic [7:0] x, y;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7)); s = 3'($urandom_range(0, 7));
      x = 8'($urandom_range(0, 255)); y = 8'($urandom_range(0, 255));
      sendOp(o, x, y, s);
      sb.push_back(model(o, x, y, s));
      waitResult(lat, busyAll, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || res !== e.res || {carry, ovf, zero} !== {e.carry, e.ovf, e.zero} || lat != e.lat) begin
        errors++; bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h sh=%0d: res %h cvz %b lat %0d required res %h cvz %b lat %0d",
                 i, o, x, y, s, res, {carry, ovf, zero}, lat, e.res, {e.carry, e.ovf, e.zero}, e.lat);
      end
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_backpressure();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
